// File: rtl/imem_loader.sv
// Instruction-memory program loader: takes a word count plus a big-endian byte
// stream from the host link and writes one 32-bit word per memory write while stalling the CPU.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter logic [31:0] ADDR_STEP = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t             state;
    logic [WORD_W-1:0]  word;
    logic [WORD_W-1:0]  addr;
    logic [CNT_W-1:0]   remaining;
    logic [IDX_W-1:0]   byte_idx;

    // Handshake and stall are pure decodes of the registered state.
    assign in_ready = (state == ST_HDR) || (state == ST_DATA);
    assign cpu_hold = (state != ST_IDLE);
    assign busy     = cpu_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            word       <= '0;
            addr       <= '0;
            remaining  <= '0;
            byte_idx   <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            done       <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) state <= ST_HDR;
                end
                ST_HDR: begin
                    // A count byte of zero means a full 256-word image.
                    if (in_valid) begin
                        remaining <= (in_data == 8'd0) ? CNT_W'(256) : CNT_W'(in_data);
                        addr      <= BASE_ADDR;
                        byte_idx  <= '0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (in_valid) begin
                        word     <= {word[WORD_W-9:0], in_data};
                        byte_idx <= byte_idx + IDX_W'(1);
                        if (byte_idx == IDX_W'(3)) begin
                            imem_we    <= 1'b1;
                            imem_waddr <= addr;
                            imem_wdata <= {word[WORD_W-9:0], in_data};
                            state      <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    addr      <= addr + ADDR_STEP;
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_DATA;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
